// File: rtl/dmem_ctrl_pkg.sv
// Shared operation codes, bus size codes and FSM state type for the MEM-stage
// data-memory controller.
package dmem_ctrl_pkg;

    localparam int W_OPER = 4;

    typedef logic [W_OPER-1:0] oper_t;

    localparam oper_t OPER_NOP = 4'h0;
    localparam oper_t OPER_LB  = 4'h1;
    localparam oper_t OPER_LBU = 4'h2;
    localparam oper_t OPER_LH  = 4'h3;
    localparam oper_t OPER_LHU = 4'h4;
    localparam oper_t OPER_LW  = 4'h5;
    localparam oper_t OPER_SB  = 4'h6;
    localparam oper_t OPER_SH  = 4'h7;
    localparam oper_t OPER_SW  = 4'h8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } dmem_state_t;

    // True for any operation that touches data memory.
    function automatic logic is_oper_mm(input oper_t op);
        return op inside {OPER_LB, OPER_LBU, OPER_LH, OPER_LHU, OPER_LW,
                          OPER_SB, OPER_SH, OPER_SW};
    endfunction

    // True for operations whose returned word must be kept for writeback.
    function automatic logic is_oper_load(input oper_t op);
        return op inside {OPER_LB, OPER_LBU, OPER_LH, OPER_LHU, OPER_LW};
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// SRAM-like data bus between the MEM-stage controller (master) and memory (slave).
interface dmem_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              d_req;
    logic              d_wr;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [3:0]        d_wstrb;
    logic [DATA_W-1:0] d_wdata;
    logic              d_addr_ok;
    logic              d_data_ok;
    logic [DATA_W-1:0] d_rdata;

    modport master (
        output d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata,
        input  d_addr_ok, d_data_ok, d_rdata
    );

    modport slave (
        input  d_req, d_wr, d_size, d_addr, d_wstrb, d_wdata,
        output d_addr_ok, d_data_ok, d_rdata
    );
endinterface

// File: rtl/dmem_ctrl_lane.sv
// Byte-lane steering: maps operation and byte offset to bus size, write
// enable, strobes and lane-replicated store data. Purely combinational.
module dmem_ctrl_lane
    import dmem_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  oper_t             oper,
    input  logic [1:0]        offset,
    input  logic [DATA_W-1:0] wdata,
    output logic [1:0]        size,
    output logic              wr,
    output logic [3:0]        wstrb,
    output logic [DATA_W-1:0] wdata_lane
);

    // Decode size/strobes; loads never assert strobes or drive store data.
    always_comb begin
        size       = SIZE_B;
        wr         = 1'b0;
        wstrb      = 4'b0000;
        wdata_lane = '0;
        case (oper)
            OPER_LB, OPER_LBU: size = SIZE_B;
            OPER_LH, OPER_LHU: size = SIZE_H;
            OPER_LW:           size = SIZE_W;
            OPER_SB: begin
                size       = SIZE_B;
                wr         = 1'b1;
                wstrb      = 4'b0001 << offset;
                wdata_lane = {4{wdata[7:0]}};
            end
            OPER_SH: begin
                size       = SIZE_H;
                wr         = 1'b1;
                wstrb      = offset[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata[15:0]}};
            end
            OPER_SW: begin
                size       = SIZE_W;
                wr         = 1'b1;
                wstrb      = 4'b1111;
                wdata_lane = wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// MEM-stage data-memory controller: issues one bus transaction per load/store,
// stalls the pipeline until it completes, and keeps the raw load word and byte
// offset for the writeback extractor.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    input  oper_t             mem_oper,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_flush,
    input  logic              ext_stall,
    output logic              stall,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        wb_offset,
    dmem_ctrl_if.master       dbus
);

    dmem_state_t       state, state_nxt;
    logic              start;
    logic              req;
    logic              active;
    logic              capture;
    logic              discard;
    logic              drop;

    logic [1:0]        lane_size;
    logic              lane_wr;
    logic [3:0]        lane_wstrb;
    logic [DATA_W-1:0] lane_wdata;

    // Reset is folded in so every output reads zero while rst is held.
    assign start = mem_valid & is_oper_mm(mem_oper) & ~mem_flush & ~rst;

    // A flush seen during the data beat itself must also suppress the capture.
    assign drop = discard | mem_flush;

    dmem_ctrl_lane #(.DATA_W(DATA_W)) u_lane (
        .oper       (mem_oper),
        .offset     (mem_addr[1:0]),
        .wdata      (mem_wdata),
        .size       (lane_size),
        .wr         (lane_wr),
        .wstrb      (lane_wstrb),
        .wdata_lane (lane_wdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: DONE always lasts at least one cycle so the same
    // instruction can never be issued twice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = dbus.d_addr_ok ? WAIT : REQ;
                end
            end
            REQ: begin
                if (dbus.d_addr_ok) begin
                    state_nxt = dbus.d_data_ok ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (dbus.d_data_ok) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (!ext_stall) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: request, stall, bus-field enable and the completion strobe.
    always_comb begin
        req     = 1'b0;
        stall   = 1'b0;
        active  = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                req    = start;
                stall  = start;
                active = start;
            end
            REQ: begin
                req     = 1'b1;
                stall   = 1'b1;
                active  = 1'b1;
                capture = dbus.d_addr_ok & dbus.d_data_ok;
            end
            WAIT: begin
                stall   = 1'b1;
                active  = 1'b1;
                capture = dbus.d_data_ok;
            end
            default: ;
        endcase
    end

    assign dbus.d_req   = req;
    assign dbus.d_wr    = active & lane_wr;
    assign dbus.d_size  = active ? lane_size : 2'b00;
    assign dbus.d_addr  = active ? {mem_addr[ADDR_W-1:2], 2'b00} : '0;
    assign dbus.d_wstrb = active ? lane_wstrb : 4'b0000;
    assign dbus.d_wdata = active ? lane_wdata : '0;

    // Writeback capture and the discard flag for flushed in-flight accesses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data   <= '0;
            wb_offset <= 2'b00;
            discard   <= 1'b0;
        end else begin
            if (capture && !drop) begin
                if (is_oper_load(mem_oper)) begin
                    wb_data <= dbus.d_rdata;
                end
                wb_offset <= mem_addr[1:0];
            end
            if (state_nxt == DONE) begin
                discard <= 1'b0;
            end else if ((state == REQ || state == WAIT) && mem_flush) begin
                discard <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus randomized
// accesses against a transaction-level reference model.
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    oper_t       mem_oper;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_flush;
    logic        ext_stall;
    logic        stall;
    logic [31:0] wb_data;
    logic [1:0]  wb_offset;

    dmem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    dmem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_oper  (mem_oper),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_flush (mem_flush),
        .ext_stall (ext_stall),
        .stall     (stall),
        .wb_data   (wb_data),
        .wb_offset (wb_offset),
        .dbus      (bus)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int          n_txn  = 0;
    logic [31:0] m_wb   = 32'h0;
    logic [1:0]  m_off  = 2'b00;
    oper_t       ops [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted bus requests, sampled mid-cycle when everything is settled.
    always @(negedge clk) begin
        if (!rst && bus.d_req && bus.d_addr_ok) n_txn++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input oper_t op);
        if (op == OPER_LB || op == OPER_LBU || op == OPER_SB) return 1;
        if (op == OPER_LH || op == OPER_LHU || op == OPER_SH) return 2;
        return 4;
    endfunction

    function automatic bit is_store(input oper_t op);
        return (op == OPER_SB || op == OPER_SH || op == OPER_SW);
    endfunction

    // One complete access: issue, optional flush, bus latencies, DONE hold.
    task automatic do_access(input oper_t op, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rd, input int alat, input int dlat,
                             input int fcyc, input int estall);
        int          c, since, nb, off, base;
        bit          acc, fin, ao, dok, flushed;
        logic [31:0] e_wd, e_addr;
        logic [3:0]  e_st;
        logic [1:0]  e_sz;

        nb   = nbytes(op);
        off  = int'(addr[1:0]);
        e_sz = (nb == 1) ? 2'd0 : (nb == 2) ? 2'd1 : 2'd2;
        e_st = 4'b0000;
        if (is_store(op)) begin
            for (int b = 0; b < 4; b++) begin
                if (b >= off && b < off + nb) e_st[b] = 1'b1;
            end
        end
        e_wd   = (nb == 1) ? (wd & 32'hFF) * 32'h01010101 :
                 (nb == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        e_addr = addr - (addr % 4);
        base   = n_txn;

        mem_valid = 1'b1; mem_oper = op; mem_addr = addr; mem_wdata = wd;
        mem_flush = 1'b0; ext_stall = 1'b0;
        acc = 0; fin = 0; c = 0; since = 0; flushed = (fcyc >= 1);

        while (!fin && c < 40) begin
            if (fcyc >= 1 && c == fcyc) mem_flush = 1'b1;
            ao  = !acc && (c == alat);
            dok = (acc && since == dlat) || (ao && dlat == 0);
            bus.d_addr_ok = ao;
            bus.d_data_ok = dok;
            bus.d_rdata   = dok ? rd : $urandom;
            @(negedge clk);
            check("busy_stall", 32'(stall), 32'd1);
            check("busy_req", 32'(bus.d_req), 32'(!acc));
            if (!acc) begin
                check("d_wr", 32'(bus.d_wr), 32'(is_store(op)));
                check("d_size", 32'(bus.d_size), 32'(e_sz));
                check("d_addr", bus.d_addr, e_addr);
                check("d_wstrb", 32'(bus.d_wstrb), 32'(e_st));
                if (is_store(op)) check("d_wdata", bus.d_wdata, e_wd);
            end
            @(posedge clk); #1;
            if (ao) begin
                acc = 1; since = 1;
            end else if (acc) begin
                since++;
            end
            if (dok) fin = 1;
            c++;
        end
        if (!fin) check("timeout", 32'd0, 32'd1);

        bus.d_addr_ok = 1'b0;
        bus.d_data_ok = 1'b0;
        if (!flushed) begin
            if (!is_store(op)) m_wb = rd;
            m_off = addr[1:0];
        end
        for (int k = 0; k <= estall; k++) begin
            ext_stall = (k < estall);
            @(negedge clk);
            check("done_stall", 32'(stall), 32'd0);
            check("done_req", 32'(bus.d_req), 32'd0);
            @(posedge clk); #1;
        end
        ext_stall = 1'b0;
        mem_valid = 1'b0;
        mem_flush = 1'b0;
        check("wb_data", wb_data, m_wb);
        check("wb_offset", 32'(wb_offset), 32'(m_off));
        check("n_txn", 32'(n_txn - base), 32'd1);
    endtask

    // A cycle with no memory instruction (bubble, flushed access or non-memory op).
    task automatic idle_cycle();
        int kind;
        kind      = $urandom_range(0, 2);
        mem_oper  = ops[$urandom_range(0, 7)];
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        mem_valid = (kind != 0);
        mem_flush = (kind == 1);
        if (kind == 2) mem_oper = OPER_NOP;
        bus.d_addr_ok = 1'($urandom_range(0, 1));
        bus.d_data_ok = 1'b0;
        @(negedge clk);
        check("idle_stall", 32'(stall), 32'd0);
        check("idle_req", 32'(bus.d_req), 32'd0);
        check("idle_wr", 32'(bus.d_wr), 32'd0);
        check("idle_wstrb", 32'(bus.d_wstrb), 32'd0);
        check("idle_addr", bus.d_addr, 32'd0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        mem_flush = 1'b0;
        bus.d_addr_ok = 1'b0;
    endtask

    initial begin
        ops[0] = OPER_LB; ops[1] = OPER_LBU; ops[2] = OPER_LH; ops[3] = OPER_LHU;
        ops[4] = OPER_LW; ops[5] = OPER_SB;  ops[6] = OPER_SH; ops[7] = OPER_SW;
        rst = 1'b1; mem_valid = 1'b0; mem_oper = OPER_NOP; mem_addr = 32'h0;
        mem_wdata = 32'h0; mem_flush = 1'b0; ext_stall = 1'b0;
        bus.d_addr_ok = 1'b0; bus.d_data_ok = 1'b0; bus.d_rdata = 32'h0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(bus.d_req), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_offset", 32'(wb_offset), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_access(OPER_LW,  32'h0000_1004, 32'h0,         32'hDEADBEEF, 0, 1, 0, 0);
        do_access(OPER_SB,  32'h0000_2003, 32'h0000_00A5, 32'h0,        0, 1, 0, 0);
        idle_cycle();
        do_access(OPER_SH,  32'h0000_2002, 32'hBEEF_1234, 32'h0,        3, 1, 0, 0);
        do_access(OPER_LBU, 32'h0000_3001, 32'h0,         32'h12345678, 0, 3, 2, 0);
        do_access(OPER_LW,  32'h0000_4000, 32'h0,         32'h0BADF00D, 1, 1, 0, 2);
        do_access(OPER_LH,  32'h0000_5002, 32'h0,         32'h55AA33CC, 2, 0, 0, 0);
        do_access(OPER_SW,  32'h0000_6000, 32'h89AB_CDEF, 32'h0,        1, 2, 1, 1);

        for (int i = 0; i < 40; i++) begin
            oper_t       op;
            logic [31:0] a;
            int          al, dl, fc, nb;
            op = ops[$urandom_range(0, 7)];
            nb = nbytes(op);
            a  = $urandom;
            if (nb == 4) a[1:0] = 2'b00;
            if (nb == 2) a[0] = 1'b0;
            al = $urandom_range(0, 3);
            dl = (al > 0) ? $urandom_range(0, 3) : $urandom_range(1, 3);
            fc = ($urandom_range(0, 4) == 0) ? $urandom_range(1, al + dl) : 0;
            do_access(op, a, $urandom, $urandom, al, dl, fc, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        // Asynchronous reset while a load is waiting for its data beat.
        do_access(OPER_LW, 32'h0000_7000, 32'h0, 32'hA1B2C3D4, 0, 1, 0, 0);
        mem_valid = 1'b1; mem_oper = OPER_LW; mem_addr = 32'h0000_8008;
        bus.d_addr_ok = 1'b1;
        @(negedge clk);
        check("pre_rst_req", 32'(bus.d_req), 32'd1);
        @(posedge clk); #1;
        bus.d_addr_ok = 1'b0;
        @(negedge clk);
        check("wait_stall", 32'(stall), 32'd1);
        #1;
        rst = 1'b1;
        mem_valid = 1'b0;
        #1;
        check("arst_stall", 32'(stall), 32'd0);
        check("arst_req", 32'(bus.d_req), 32'd0);
        check("arst_wb_data", wb_data, 32'd0);
        m_wb = 32'h0; m_off = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.d_data_ok = 1'b1;
        bus.d_rdata = 32'hCAFEF00D;
        @(negedge clk);
        check("late_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        bus.d_data_ok = 1'b0;
        @(negedge clk);
        check("late_wb_data", wb_data, m_wb);
        check("late_wb_offset", 32'(wb_offset), 32'(m_off));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
